// File: rtl/anspwm_pkg.sv
// Shared types for the ANS-PWM chain: sign-magnitude correction terms and the
// width of the final summation.
package anspwm_pkg;

    localparam int W_STAGE = 16;
    localparam int SUM_W   = W_STAGE + 3;

    typedef struct packed {
        logic [W_STAGE-1:0] mag;
        logic               sgn;
    } sm_t;

    typedef logic signed [SUM_W-1:0] sum_t;

    // Sign-magnitude to two's complement at summation width.
    function automatic sum_t sm_to_signed(input sm_t v);
        sum_t m;
        m = sum_t'({3'b000, v.mag});
        return v.sgn ? -m : m;
    endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Free-running PWM carrier: period counter, per-period sample request, boundary
// load of the active duty from the pending buffer, underrun flag and PWM output.
module pwm_carrier #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS:0]   pending_duty,
    input  logic                pending_valid,
    input  logic                clr_flags,
    output logic                consume,
    output logic                sample_req,
    output logic                pwm_out,
    output logic [PWM_BITS:0]   duty_active,
    output logic                underrun
);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS:0]   duty_active_q, duty_active_d;
    logic                pwm_q, pwm_d;
    logic                underrun_q, underrun_d;

    always_comb begin
        cnt_d         = cnt_q + PWM_BITS'(1);
        duty_active_d = duty_active_q;
        underrun_d    = underrun_q;
        consume       = 1'b0;
        if (clr_flags) underrun_d = 1'b0;
        // Load at the last count so the new duty is in force from cnt==0.
        if (cnt_q == CNT_LAST) begin
            if (pending_valid) begin
                duty_active_d = pending_duty;
                consume       = 1'b1;
            end else begin
                underrun_d    = 1'b1;
            end
        end
        pwm_d = ({1'b0, cnt_q} < duty_active_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_req  = (cnt_q == '0) && !rst;
    assign pwm_out     = pwm_q;
    assign duty_active = duty_active_q;
    assign underrun    = underrun_q;

endmodule

// File: rtl/mash_sum_pwm.sv
// Final ANS-PWM stage: sums stage-1 value with stage-2/3 corrections, scales and
// clamps to a PWM duty, holds one pending duty and feeds the PWM carrier.
module mash_sum_pwm
    import anspwm_pkg::*;
#(
    parameter int W        = W_STAGE,
    parameter int PWM_BITS = 8,
    parameter int SHIFT    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [W-1:0]        q1,
    input  logic [W-1:0]        c2,
    input  logic                c2_sgn,
    input  logic [W-1:0]        c3,
    input  logic                c3_sgn,
    input  logic                clr_flags,
    output logic                sample_req,
    output logic                pwm_out,
    output logic [PWM_BITS:0]   duty_active,
    output logic                underrun,
    output logic                overrun
);
    localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

    sm_t               c2_sm, c3_sm;
    sum_t              sum_q, sum_d, s;
    logic              v1_q, v2_q;
    logic [PWM_BITS:0] duty_q, duty_d;
    logic [PWM_BITS:0] pending_duty_q, pending_duty_d;
    logic              pending_valid_q, pending_valid_d;
    logic              overrun_q, overrun_d;
    logic              consume;

    assign c2_sm = '{mag: c2, sgn: c2_sgn};
    assign c3_sm = '{mag: c3, sgn: c3_sgn};

    always_comb begin
        sum_d = sum_t'({3'b000, q1}) + sm_to_signed(c2_sm) + sm_to_signed(c3_sm);

        s = sum_q >>> SHIFT;
        if (s[SUM_W-1])
            duty_d = '0;
        else if (s > sum_t'(DUTY_FULL))
            duty_d = DUTY_FULL;
        else
            duty_d = s[PWM_BITS:0];

        pending_duty_d  = pending_duty_q;
        pending_valid_d = pending_valid_q;
        overrun_d       = overrun_q;
        if (clr_flags) overrun_d = 1'b0;
        // A write in the consume cycle refills the buffer rather than clobbering it.
        if (v2_q) begin
            pending_duty_d  = duty_q;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !consume) overrun_d = 1'b1;
        end else if (consume) begin
            pending_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q           <= '0;
            v1_q            <= 1'b0;
            duty_q          <= '0;
            v2_q            <= 1'b0;
            pending_duty_q  <= '0;
            pending_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            sum_q           <= sum_d;
            v1_q            <= in_valid;
            duty_q          <= duty_d;
            v2_q            <= v1_q;
            pending_duty_q  <= pending_duty_d;
            pending_valid_q <= pending_valid_d;
            overrun_q       <= overrun_d;
        end
    end

    pwm_carrier #(.PWM_BITS(PWM_BITS)) u_carrier (
        .clk           (clk),
        .rst           (rst),
        .pending_duty  (pending_duty_q),
        .pending_valid (pending_valid_q),
        .clr_flags     (clr_flags),
        .consume       (consume),
        .sample_req    (sample_req),
        .pwm_out       (pwm_out),
        .duty_active   (duty_active),
        .underrun      (underrun)
    );

    assign overrun = overrun_q;

endmodule

// File: tb/tb_mash_sum_pwm.sv
// Self-checking bench for mash_sum_pwm: a duty model feeds an expected queue that
// is checked against duty_active and measured PWM high time each period.
module tb_mash_sum_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] q1 = '0, c2 = '0, c3 = '0;
    logic        c2_sgn = 1'b0, c3_sgn = 1'b0;
    logic        clr_flags = 1'b0;
    logic        sample_req, pwm_out, underrun, overrun;
    logic [8:0]  duty_active;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mash_sum_pwm #(.W(16), .PWM_BITS(8), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .q1(q1), .c2(c2), .c2_sgn(c2_sgn), .c3(c3), .c3_sgn(c3_sgn),
        .clr_flags(clr_flags), .sample_req(sample_req), .pwm_out(pwm_out),
        .duty_active(duty_active), .underrun(underrun), .overrun(overrun)
    );

    function automatic int model_duty(input int a, input int b, input bit bs,
                                      input int c, input bit cs);
        int sum, s;
        sum = a + (bs ? -b : b) + (cs ? -c : c);
        s = sum >>> 8;
        if (s < 0) return 0;
        if (s > 256) return 256;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle input sample; expected duty goes to the scoreboard if push is set.
    task automatic send(input int a, input int b, input bit bs, input int c,
                        input bit cs, input bit clr, input bit push);
        q1 = 16'(a); c2 = 16'(b); c2_sgn = bs; c3 = 16'(c); c3_sgn = cs;
        in_valid = 1'b1;
        clr_flags = clr;
        if (push) exp_q.push_back(model_duty(a, b, bs, c, cs));
        tick();
        in_valid = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        tick();
        while (sample_req !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        n_tests++;
        if (sample_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_req: sample_req=%b after %0d cycles, required 1", sample_req, n);
        end
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    // Called at a cnt==0 cycle; checks duty_active, then counts pwm_out over the period.
    task automatic measure(input int exp_duty, input string name);
        int hi;
        n_tests++;
        if (duty_active !== 9'(exp_duty)) begin
            n_fail++;
            $display("FAIL %s duty_active: got %0d, required %0d", name, duty_active, exp_duty);
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm_out === 1'b1) hi++;
        end
        n_tests++;
        if (hi != exp_duty) begin
            n_fail++;
            $display("FAIL %s pwm_high: got %0d cycles, required %0d", name, hi, exp_duty);
        end
        n_tests++;
        if (sample_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s period_len: sample_req=%b after 256 cycles, required 1", name, sample_req);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_tests++;
        if ({sample_req, pwm_out, duty_active, underrun, overrun} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b pwm=%b duty=%0d ur=%b or=%b, required all 0",
                     sample_req, pwm_out, duty_active, underrun, overrun);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (sample_req !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req: sample_req=%b, required 1", sample_req);
        end
    endtask

    task automatic test_nominal();
        send(16'h8000, 16'h0100, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b1);
        wait_req();
        n_tests++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_flags: ur=%b or=%b, required 0 0", underrun, overrun);
        end
        measure(pop_exp(), "nominal");
    endtask

    task automatic test_neg_clamp();
        send(16'h0010, 16'h0200, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        wait_req();
        n_tests++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_clamp_flags: ur=%b or=%b, required 0 0", underrun, overrun);
        end
        measure(pop_exp(), "neg_clamp");
    endtask

    task automatic test_pos_clamp();
        send(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        wait_req();
        measure(pop_exp(), "pos_clamp");
    endtask

    task automatic test_underrun();
        send(16'h4000, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        wait_req();
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_pre: underrun=%b, required 0", underrun);
        end
        measure(pop_exp(), "underrun_p1");
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: underrun=%b, required 1", underrun);
        end
        measure(64, "underrun_hold");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clr: underrun=%b, required 0", underrun);
        end
        wait_req();
    endtask

    task automatic test_overrun();
        int dropped;
        send(40 * 256, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        repeat (9) tick();
        send(200 * 256, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        dropped = exp_q.pop_front();
        wait_req();
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: overrun=%b, required 1 (dropped %0d)", overrun, dropped);
        end
        measure(pop_exp(), "overrun_play");
    endtask

    task automatic test_back_to_back();
        send(100 * 256, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        repeat (252) tick();
        send(30 * 256, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        n_tests++;
        if (sample_req !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_boundary: req=%b or=%b, required 1 0", sample_req, overrun);
        end
        measure(pop_exp(), "collide_old");
        n_tests++;
        if (overrun !== 1'b0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_flags: or=%b ur=%b, required 0 0", overrun, underrun);
        end
        measure(pop_exp(), "collide_new");
    endtask

    task automatic test_reset_mid();
        send(16'h8000, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        wait_req();
        measure(pop_exp(), "mid_pre");
        repeat (99) tick();
        send(16'h4000, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        n_tests++;
        if ({pwm_out, duty_active, underrun, overrun, sample_req} !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: pwm=%b duty=%0d ur=%b or=%b req=%b, required all 0",
                     pwm_out, duty_active, underrun, overrun, sample_req);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (sample_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_cnt0: sample_req=%b, required 1", sample_req);
        end
        measure(0, "mid_reset_period");
        n_tests++;
        if (duty_active !== 9'd0 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_flush: duty=%0d ur=%b, required 0 1", duty_active, underrun);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_neg_clamp();
        test_pos_clamp();
        test_underrun();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mash_sum_pwm.md
Name: mash_sum_pwm

Overview:
- Final output stage of the ANS-PWM chain; sits directly downstream of stage2/stage3.
- Performs the final signed addition of the stage-1 quantized value and the sign-magnitude correction terms from the later stages (stage2 C/Csgn, stage3 equivalent).
- Scales and clamps the sum to a PWM duty, buffers it one deep, and drives a free-running PWM carrier.
- Requests each new sample once per PWM period.

Parameters:
- W, 16, width of every stage magnitude input.
- PWM_BITS, 8, PWM period = 2^PWM_BITS clk cycles; duty width PWM_BITS+1.
- SHIFT, 8, arithmetic right shift applied to the sum before clamping.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- in_valid  in  1  q1/c2/c3 and their signs valid this cycle
- q1  in  W  stage-1 quantized value, unsigned, always positive
- c2  in  W  stage-2 correction magnitude
- c2_sgn  in  1  1 = c2 negative
- c3  in  W  stage-3 correction magnitude
- c3_sgn  in  1  1 = c3 negative
- clr_flags  in  1  clears underrun/overrun
- sample_req  out  1  one-cycle pulse at PWM period start, asking for the next sample
- pwm_out  out  1  PWM output, registered
- duty_active  out  PWM_BITS+1  duty currently being played
- underrun  out  1  sticky: period boundary reached with no pending sample
- overrun  out  1  sticky: pending sample overwritten before use

Behaviour:
- Reset (rst=1 at a clk edge) sets all of the following next cycle:
  - cnt=0, duty_active=0, pending empty, pwm_out=0, sample_req=0, underrun=0, overrun=0.
  - Pipeline valids are cleared and in-flight samples are discarded.
- P1, sum (registered, 1 clk):
  - sum = q1 + (c2_sgn ? -c2 : c2) + (c3_sgn ? -c3 : c3), computed as W+3 bit two's complement.
  - Range -2(2^W-1)..3(2^W-1), so no overflow is possible.
  - v1 <= in_valid.
- P2, scale/clamp (registered, 1 clk):
  - s = sum >>> SHIFT (arithmetic shift, floor).
  - duty = 0 if s<0; 2^PWM_BITS if s>2^PWM_BITS; else s.
  - v2 <= v1.
- Pending buffer (1 deep):
  - v2=1 writes pending_duty and sets pending_valid.
  - If pending_valid is already 1 and it is not consumed in the same cycle: overwrite (newest wins) and set overrun.
- Input-to-pending latency: 2 clk.
- Counter:
  - cnt is PWM_BITS wide and free-running: increments every cycle, wraps 2^PWM_BITS-1 -> 0.
  - sample_req = 1 in the cycle where cnt==0; the first request is the first cycle after reset release.
- Period boundary (cnt==2^PWM_BITS-1):
  - If pending_valid: duty_active <= pending_duty, pending_valid <= 0.
  - Else: duty_active holds and underrun <= 1.
  - The new duty takes effect at cnt==0.
- Simultaneous consume and write (v2=1 in the boundary cycle):
  - The old pending goes to duty_active.
  - The new value lands in pending with pending_valid=1.
  - No overrun.
- pwm_out <= (cnt < duty_active), so it lags cnt by 1 clk.
  - duty 0 gives constant 0.
  - duty 2^PWM_BITS gives constant 1 with no glitch at wrap.
- Flags:
  - clr_flags clears underrun and overrun.
  - If clr_flags coincides with a set event, the set event wins.
- in_valid is honoured in any cycle, with no backpressure. Upstream is expected to respond to sample_req within one period.

Decomposition:
- Shared package anspwm_pkg holds:
  - the sign-magnitude struct {logic [15:0] mag; logic sgn;}, reused by the stage2/stage3 outputs;
  - constants W_STAGE=16 and SUM_W=W_STAGE+3.
- One sub-module, pwm_carrier, owns:
  - cnt, sample_req, the boundary load of duty_active, underrun, and pwm_out.
  - Its inputs are pending_duty/pending_valid; its output is a consume pulse.
- The top level holds P1, P2, the pending buffer and overrun.

Test Plan:
All scenarios use PWM_BITS=8, SHIFT=8.
- Nominal:
  - Stimulus: q1=0x8000, c2=0x0100 (+), c3=0x0080 (-), one in_valid after sample_req.
  - Response: sum=32896, duty 128; next period pwm_out high exactly 128 of 256 cycles, duty_active=128.
- Negative clamp:
  - Stimulus: q1=0x0010, c2=0x0200 (-), c3=0.
  - Response: sum=-496, duty 0; pwm_out 0 for the whole period, no flags.
- Positive clamp:
  - Stimulus: q1=c2=c3=0xFFFF, all positive.
  - Response: s=767, duty 256; pwm_out 1 every cycle of the period, including the wrap.
- Underrun:
  - Stimulus: one sample (duty 64), then none.
  - Response: duty_active stays 64 across the next periods; underrun=1 from the first empty boundary; clr_flags clears it.
- Overrun and boundary collision:
  - Stimulus: two in_valid 10 cycles apart in one period (duties 40, 200).
  - Response: 200 is played and overrun=1.
  - Then time a write with v2 on cnt==255: no overrun, old pending played, new one pending.
- Reset mid-period:
  - Stimulus: assert rst at cnt=100 with duty 128 active and a sample in P1.
  - Response: next cycle cnt=0, pwm_out=0, duty_active=0, pending empty, flags 0; the in-flight sample is never played.
